uart_echo_ctrl: RTL and testbench

//   Parametrised echo/forwarding engine between the uart core's RX FIFO read port and TX FIFO write port.

---
 rtl/uart_echo_pkg.sv | 20 ++
 rtl/uart_echo_ctrl_if.sv | 22 ++
 rtl/uart_echo_linebuf.sv | 27 ++
 rtl/uart_echo_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_uart_echo_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the uart echo/forwarding engine.
// Optional build macro: UART_ECHO_UPCASE_EN (upper-case letters at push time).
package uart_echo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HOLD    = 2'b01,
        COLLECT = 2'b10,
        DRAIN   = 2'b11
    } state_t;

    localparam logic [1:0] MODE_ECHO    = 2'b00;
    localparam logic [1:0] MODE_LINE    = 2'b01;
    localparam logic [1:0] MODE_DISCARD = 2'b10;

    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_LC_Z = 8'h7A;
    localparam logic [7:0] UPCASE_OFS = 8'h20;

endpackage

// File: rtl/uart_echo_ctrl_if.sv
// FIFO-side handshake bundle: RX FIFO read port and TX FIFO write port.
// master = echo controller, slave = uart core FIFOs.
interface uart_echo_ctrl_if #(parameter int DBIT = 8);

    logic            rx_empty;
    logic [DBIT-1:0] rd_data;
    logic            rd_uart;
    logic            tx_full;
    logic [DBIT-1:0] w_data;
    logic            wr_uart;

    modport master (
        input  rx_empty, rd_data, tx_full,
        output rd_uart, w_data, wr_uart
    );

    modport slave (
        output rx_empty, rd_data, tx_full,
        input  rd_uart, w_data, wr_uart
    );

endinterface

// File: rtl/uart_echo_linebuf.sv
// Line buffer storage: LINE_DEPTH x DBIT register array, one write port,
// one asynchronous read port. Pointers are owned by the parent.
module uart_echo_linebuf #(
    parameter int DBIT       = 8,
    parameter int LINE_DEPTH = 16,
    parameter int PTR_W      = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [DBIT-1:0]  wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [DBIT-1:0]  rdata
);

    logic [DBIT-1:0] mem [LINE_DEPTH];

    // Storage write; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_echo_ctrl.sv
// Echo/forwarding engine between the uart RX FIFO read port and TX FIFO
// write port. Modes: byte echo, line-buffered echo, discard.
// Optional build macro: UART_ECHO_UPCASE_EN -- lower-case ASCII letters are
// pushed as upper case (requires DBIT == 8).
module uart_echo_ctrl
    import uart_echo_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int LINE_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [DBIT-1:0]   term_char,
    input  logic              cnt_clr,
    uart_echo_ctrl_if.master  fifo,
    output logic              busy,
    output logic              line_trunc,
    output logic [CNT_W-1:0]  rx_count,
    output logic [CNT_W-1:0]  tx_count
);

    localparam int PTR_W  = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
    localparam int LCNT_W = $clog2(LINE_DEPTH + 1);

    if (LINE_DEPTH < 2) begin : g_depth_chk
        $error("uart_echo_ctrl: LINE_DEPTH must be >= 2");
    end

    state_t            state_q, state_d;
    logic [DBIT-1:0]   hold_r;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LCNT_W-1:0] line_cnt;
    logic [DBIT-1:0]   buf_rdata;
    logic [DBIT-1:0]   raw_data;
    logic              pop, push;
    logic              buf_we, hold_load, line_clear;
    logic              is_term, line_full, drain_last;

    assign is_term    = (fifo.rd_data == term_char);
    assign line_full  = (line_cnt == LCNT_W'(LINE_DEPTH - 1));
    assign drain_last = ((LCNT_W'(rd_ptr) + 1'b1) == line_cnt);

    uart_echo_linebuf #(
        .DBIT       (DBIT),
        .LINE_DEPTH (LINE_DEPTH),
        .PTR_W      (PTR_W)
    ) u_linebuf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_ptr),
        .wdata (fifo.rd_data),
        .raddr (rd_ptr),
        .rdata (buf_rdata)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and FIFO handshakes; both strobes are held low while reset
    // is asserted so the FIFOs see nothing before the first clock edge.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        push       = 1'b0;
        buf_we     = 1'b0;
        hold_load  = 1'b0;
        line_clear = 1'b0;
        line_trunc = 1'b0;
        raw_data   = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    case (mode)
                        MODE_LINE: state_d = COLLECT;
                        MODE_DISCARD: begin
                            if (!fifo.rx_empty) begin
                                pop = 1'b1;
                            end
                        end
                        default: begin
                            if (!fifo.rx_empty) begin
                                pop       = 1'b1;
                                hold_load = 1'b1;
                                state_d   = HOLD;
                            end
                        end
                    endcase
                end
                HOLD: begin
                    raw_data = hold_r;
                    if (!fifo.tx_full) begin
                        push = 1'b1;
                        if (!fifo.rx_empty) begin
                            pop       = 1'b1;
                            hold_load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                COLLECT: begin
                    if (!fifo.rx_empty) begin
                        pop    = 1'b1;
                        buf_we = 1'b1;
                        if (is_term) begin
                            state_d = DRAIN;
                        end else if (line_full) begin
                            state_d    = DRAIN;
                            line_trunc = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    raw_data = buf_rdata;
                    if (!fifo.tx_full) begin
                        push = 1'b1;
                        if (drain_last) begin
                            state_d    = IDLE;
                            line_clear = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Echo holding register and line buffer pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_r   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            line_cnt <= '0;
        end else begin
            if (hold_load) begin
                hold_r <= fifo.rd_data;
            end
            if (line_clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                line_cnt <= '0;
            end else begin
                if (buf_we) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    line_cnt <= line_cnt + 1'b1;
                end
                if (push && state_q == DRAIN) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Wrapping byte counters; a clear request beats a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_count <= '0;
            tx_count <= '0;
        end else if (cnt_clr) begin
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            if (pop) begin
                rx_count <= rx_count + 1'b1;
            end
            if (push) begin
                tx_count <= tx_count + 1'b1;
            end
        end
    end

    assign fifo.rd_uart = pop;
    assign fifo.wr_uart = push;
    assign busy         = (state_q != IDLE);

`ifdef UART_ECHO_UPCASE_EN
    if (DBIT != 8) begin : g_upcase_chk
        $error("uart_echo_ctrl: UART_ECHO_UPCASE_EN requires DBIT == 8");
    end

    // Upper-case conversion on the push path only; terminator compare stays raw.
    always_comb begin
        fifo.w_data = raw_data;
        if (raw_data >= DBIT'(ASCII_LC_A) && raw_data <= DBIT'(ASCII_LC_Z)) begin
            fifo.w_data = raw_data - DBIT'(UPCASE_OFS);
        end
    end
`else
    // Bytes leave unmodified.
    always_comb begin
        fifo.w_data = raw_data;
    end
`endif

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Scoreboard bench for uart_echo_ctrl: an RX FIFO queue feeds the DUT, a
// stream-level model predicts the pushed byte sequence, and a negedge monitor
// compares every push against the expected queue.
module tb_uart_echo_ctrl;

    localparam int DBIT       = 8;
    localparam int LINE_DEPTH = 4;
    localparam int CNT_W      = 8;

    typedef logic [7:0] bq_t[$];

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       mode = 2'b00;
    logic [DBIT-1:0]  term_char = 8'h0D;
    logic             cnt_clr = 1'b0;
    logic             busy;
    logic             line_trunc;
    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] tx_count;

    uart_echo_ctrl_if #(.DBIT(DBIT)) fifo ();

    uart_echo_ctrl #(
        .DBIT       (DBIT),
        .LINE_DEPTH (LINE_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .term_char  (term_char),
        .cnt_clr    (cnt_clr),
        .fifo       (fifo),
        .busy       (busy),
        .line_trunc (line_trunc),
        .rx_count   (rx_count),
        .tx_count   (tx_count)
    );

    always #5 clk = ~clk;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int  push_cyc[$];
    int  pop_cyc[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    bit  pop_pending = 0;
    int  tx_mode = 0;          // 0 never full, 1 random, 2 always full
    int  n_pop = 0;
    int  n_push = 0;
    int  n_trunc = 0;
    int  first_push_pops = -1;
    int  m_rx = 0;
    int  m_tx = 0;
    int  m_line = 0;
    int  m_trunc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] up(input logic [7:0] b);
`ifdef UART_ECHO_UPCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    // Stream-level model: every byte is popped; ECHO forwards all bytes in
    // order, LINE forwards whole lines (terminator or LINE_DEPTH bytes),
    // DISCARD forwards nothing.
    function automatic void model(input bq_t bs);
        foreach (bs[i]) begin
            m_rx++;
            if (mode != 2'b10) begin
                exp_q.push_back(up(bs[i]));
                m_tx++;
                if (mode == 2'b01) begin
                    m_line++;
                    if (bs[i] == term_char) begin
                        m_line = 0;
                    end else if (m_line == LINE_DEPTH) begin
                        m_trunc++;
                        m_line = 0;
                    end
                end
            end
        end
    endfunction

    // RX FIFO / TX FIFO behaviour: apply the pop decided at the last negedge,
    // then present the new head word and the TX full flag.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (pop_pending && rx_q.size() > 0) void'(rx_q.pop_front());
        pop_pending = 0;
        fifo.rx_empty = (rx_q.size() == 0);
        fifo.rd_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        case (tx_mode)
            0:       fifo.tx_full = 1'b0;
            2:       fifo.tx_full = 1'b1;
            default: fifo.tx_full = ($urandom_range(0, 1) == 0);
        endcase
    end

    // Monitor: protocol rules plus scoreboard compare of every pushed byte.
    always @(negedge clk) begin
        if (!reset) begin
            if (fifo.rd_uart) begin
                check("rd_uart_while_empty", fifo.rx_empty, 0);
                pop_pending = 1;
                n_pop++;
                pop_cyc.push_back(cyc);
            end
            if (fifo.wr_uart) begin
                check("wr_uart_while_full", fifo.tx_full, 0);
                n_push++;
                push_cyc.push_back(cyc);
                if (first_push_pops < 0) first_push_pops = n_pop;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_push: got w_data %0h, required no push (t=%0t)", fifo.w_data, $time);
                end else begin
                    check("w_data", fifo.w_data, exp_q.pop_front());
                end
            end
            if (line_trunc) n_trunc++;
        end
    end

    task automatic feed(input bq_t bs, input bit burst);
        model(bs);
        if (burst) begin
            @(negedge clk);
            foreach (bs[i]) rx_q.push_back(bs[i]);
        end else begin
            foreach (bs[i]) begin
                @(negedge clk);
                rx_q.push_back(bs[i]);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rx_q.size() == 0 && exp_q.size() == 0 && !pop_pending) break;
        end
        repeat (3) @(negedge clk);
        check("drain_timeout_left", rx_q.size() + exp_q.size(), 0);
    endtask

    task automatic phase_end();
        check("rx_count", rx_count, CNT_W'(m_rx));
        check("tx_count", tx_count, CNT_W'(m_tx));
        check("line_trunc_pulses", n_trunc, m_trunc);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_rd_uart", fifo.rd_uart, 0);
        check("rst_wr_uart", fifo.wr_uart, 0);
        check("rst_w_data", fifo.w_data, 0);
        check("rst_line_trunc", line_trunc, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_tx_count", tx_count, 0);
        rx_q.delete();
        exp_q.delete();
        pop_pending = 0;
        m_rx = 0; m_tx = 0; m_line = 0; m_trunc = 0; n_trunc = 0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t bs;
        int  p0, w0, rel, i;

        fifo.rx_empty = 1'b1;
        fifo.rd_data  = '0;
        fifo.tx_full  = 1'b0;

        // Back-to-back echo: one push per cycle, one cycle after each pop.
        mode = 2'b00; tx_mode = 0;
        apply_reset();
        push_cyc.delete(); pop_cyc.delete();
        bs = '{8'h41, 8'h42, 8'h43};
        feed(bs, 1);
        wait_done();
        phase_end();
        check("b2b_push_count", push_cyc.size(), 3);
        if (push_cyc.size() == 3 && pop_cyc.size() == 3) begin
            check("b2b_push1_cycle", push_cyc[1], push_cyc[0] + 1);
            check("b2b_push2_cycle", push_cyc[2], push_cyc[0] + 2);
            check("echo_latency", push_cyc[0], pop_cyc[0] + 1);
        end

        // Stall in HOLD while TX FIFO is full, then push on release.
        apply_reset();
        tx_mode = 2;
        p0 = n_pop;
        bs = '{8'h55, 8'h66};
        feed(bs, 1);
        for (i = 0; i < 20 && n_pop == p0; i++) @(negedge clk);
        @(negedge clk);
        check("hold_first_pop", n_pop - p0, 1);
        p0 = n_pop; w0 = n_push;
        repeat (5) @(negedge clk);
        check("stall_no_pop", n_pop, p0);
        check("stall_no_push", n_push, w0);
        push_cyc.delete();
        rel = cyc;
        tx_mode = 0;
        wait_done();
        phase_end();
        if (push_cyc.size() > 0) check("release_push_cycle", push_cyc[0], rel + 1);
        else check("release_push_count", push_cyc.size(), 2);

        // LINE: nothing pushed until the terminator is popped.
        mode = 2'b01;
        apply_reset();
        first_push_pops = -1;
        p0 = n_pop;
        bs = '{8'h68, 8'h69, 8'h0D};
        feed(bs, 1);
        wait_done();
        phase_end();
        check("line_pops_before_first_push", first_push_pops - p0, 3);

        // LINE truncation: 6 bytes without terminator on a 4-deep buffer.
        apply_reset();
        tx_mode = 1;
        bs = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h0D};
        feed(bs, 0);
        wait_done();
        phase_end();

        // DISCARD: bytes popped, nothing pushed; then clear against pops.
        mode = 2'b10;
        apply_reset();
        w0 = n_push;
        bs.delete();
        for (i = 0; i < 10; i++) bs.push_back(8'($urandom_range(0, 255)));
        feed(bs, 0);
        wait_done();
        phase_end();
        check("discard_no_push", n_push, w0);
        @(negedge clk);
        cnt_clr = 1'b1;
        bs = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        feed(bs, 1);
        wait_done();
        cnt_clr = 1'b0;
        m_rx = 0;
        @(negedge clk);
        check("cnt_clr_wins", rx_count, 0);
        bs = '{8'h7E};
        feed(bs, 1);
        wait_done();
        phase_end();

        // Randomised phases across all mode codes with random TX back-pressure.
        for (int p = 0; p < 6; p++) begin
            mode = (p == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            apply_reset();
            tx_mode = 1;
            bs.delete();
            if (p == 0) begin
                bs = '{8'h61, 8'h7A, 8'h7B, 8'h60, 8'h41};
                for (i = 0; i < 300; i++) bs.push_back(8'($urandom_range(0, 255)));
            end else if (mode == 2'b01) begin
                for (int l = 0; l < 8; l++) begin
                    for (int k = 0; k < $urandom_range(0, 6); k++)
                        bs.push_back(8'($urandom_range(0, 255)));
                    bs.push_back(term_char);
                end
            end else begin
                for (i = 0; i < $urandom_range(20, 80); i++)
                    bs.push_back(8'($urandom_range(0, 255)));
            end
            feed(bs, (p % 2) == 1);
            wait_done();
            phase_end();
        end

        // Reset while a line is draining against a full TX FIFO.
        mode = 2'b01;
        apply_reset();
        tx_mode = 2;
        p0 = n_pop;
        bs = '{8'h61, 8'h62, 8'h63, 8'h0D, 8'h7A};
        feed(bs, 1);
        for (i = 0; i < 50 && rx_q.size() != 1; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("drain_pops", n_pop - p0, 4);
        check("drain_busy", busy, 1);
        check("drain_rx_left", rx_q.size(), 1);
        apply_reset();
        tx_mode = 0;
        mode = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
